// File: rtl/rx_bit_timer.sv
// Receive-path bit timer: phase counter, sample-point strobe, bit/byte counting with edge resync.
// Optional macro RX_BIT_TIMER_STUFF_EN: skip_bit suppresses counting of stuffed-bit strobes.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned SAMPLE_POINT  = 3,
  parameter int unsigned BITS_PER_BYTE = 8,
  parameter int unsigned CNT_BITS      = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                enable_timer,
  input  logic                resync,
  input  logic                skip_bit,
  output logic                shift_strobe,
  output logic                byte_received,
  output logic [CNT_BITS-1:0] bit_count,
  output logic                busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_BITS-1:0] LAST_PHASE   = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [CNT_BITS-1:0] SAMPLE_PHASE = CNT_BITS'(SAMPLE_POINT);
  localparam logic [CNT_BITS-1:0] LAST_BIT     = CNT_BITS'(BITS_PER_BYTE - 1);

  logic [0:0]          state;
  logic [CNT_BITS-1:0] phase;
  logic                count_en;

  assign busy         = (state == RUN);
  assign shift_strobe = (state == RUN) && (phase == SAMPLE_PHASE);

`ifdef RX_BIT_TIMER_STUFF_EN
  assign count_en = shift_strobe && !skip_bit;
`else
  logic unused_skip_bit;
  assign unused_skip_bit = skip_bit;
  assign count_en        = shift_strobe;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      phase         <= '0;
      bit_count     <= '0;
      byte_received <= 1'b0;
    end else begin
      byte_received <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_timer) begin
            state <= RUN;
            phase <= '0;
          end
        end
        default: begin
          if (!enable_timer) begin
            // Disable outranks resync and a coincident final strobe.
            state     <= IDLE;
            phase     <= '0;
            bit_count <= '0;
          end else begin
            // Resync treats this cycle as phase 0, so the next phase is 1.
            if (resync)
              phase <= CNT_BITS'(1);
            else if (phase == LAST_PHASE)
              phase <= '0;
            else
              phase <= phase + 1'b1;

            if (count_en) begin
              if (bit_count == LAST_BIT) begin
                bit_count     <= '0;
                byte_received <= 1'b1;
              end else begin
                bit_count <= bit_count + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios plus random traffic against a timeline model.
module tb_rx_bit_timer;

  localparam int C   = 8;
  localparam int S   = 3;
  localparam int BPB = 8;

`ifdef RX_BIT_TIMER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  logic       clk;
  logic       n_rst;
  logic       enable_timer;
  logic       resync;
  logic       skip_bit;
  logic       shift_strobe;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  // Model: running flag, cycles since last phase-0 alignment, strobes accepted this run.
  bit m_run;
  int m_t;
  int m_acc;
  bit m_byte;

  rx_bit_timer #(
    .CLKS_PER_BIT (C),
    .SAMPLE_POINT (S),
    .BITS_PER_BYTE(BPB),
    .CNT_BITS     (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .resync       (resync),
    .skip_bit     (skip_bit),
    .shift_strobe (shift_strobe),
    .byte_received(byte_received),
    .bit_count    (bit_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_strobe();
    return m_run && ((m_t % C) == S);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_acc = 0; m_byte = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit rs, input bit sk);
    bit acc;
    if (!n_rst) begin
      model_reset();
    end else if (!m_run) begin
      m_byte = 1'b0;
      if (en) begin m_run = 1'b1; m_t = 0; m_acc = 0; end
    end else if (!en) begin
      model_reset();
    end else begin
      acc    = m_strobe() && !(STUFF && sk);
      m_byte = acc && (((m_acc + 1) % BPB) == 0);
      if (acc) m_acc++;
      m_t = rs ? 1 : m_t + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".strobe"}, {7'd0, shift_strobe},  {7'd0, m_strobe()});
    chk({tag, ".byte"},   {7'd0, byte_received}, {7'd0, m_byte});
    chk({tag, ".count"},  {4'd0, bit_count},     8'(m_acc % BPB));
    chk({tag, ".busy"},   {7'd0, busy},          {7'd0, m_run});
  endtask

  // Called at a falling edge: drive, take the rising edge, then check at the next falling edge.
  task automatic step(input bit en, input bit rs, input bit sk, input string tag);
    enable_timer = en; resync = rs; skip_bit = sk;
    @(posedge clk);
    model_edge(en, rs, sk);
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    int first_e, last_e, byte_e, nstr, wait_n, guard;
    bit en, rs, sk;

    n_rst = 1'b0; enable_timer = 1'b1; resync = 1'b0; skip_bit = 1'b0;
    model_reset();
    @(negedge clk);
    chk_all("reset");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "reset_hold");
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, "idle");
    step(1'b0, 1'b1, 1'b0, "idle_resync");

    // Full byte: edge 0 is the first edge with enable high.
    first_e = -1; last_e = -1; byte_e = -1; nstr = 0;
    for (int e = 0; e <= 67; e++) begin
      step(1'b1, 1'b0, 1'b0, "full_byte");
      if (shift_strobe) begin
        nstr++;
        last_e = e;
        if (first_e < 0) first_e = e;
      end
      if (byte_received) byte_e = e;
    end
    chk("first_strobe_edge", 8'(first_e), 8'd3);
    chk("strobe_total",      8'(nstr),    8'd9);
    chk("byte_edge",         8'(byte_e),  8'd60);
    chk("next_strobe_edge",  8'(last_e),  8'd67);

    // Resync at phase 6: strobe two cycles later.
    guard = 0;
    while ((m_t % C) != 6 && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, "pre_resync");
      guard++;
    end
    chk("resync_reach", 8'(m_t % C), 8'd6);
    step(1'b1, 1'b1, 1'b0, "resync");
    wait_n = 0;
    guard  = 0;
    while (!shift_strobe && guard < 20) begin
      step(1'b1, 1'b0, 1'b0, "post_resync");
      wait_n++;
      guard++;
    end
    chk("resync_gap", 8'(wait_n), 8'd2);

    // Abort after the 4th strobe of a fresh run.
    step(1'b0, 1'b0, 1'b0, "abort_clear");
    guard = 0;
    while ((m_acc % BPB) != 4 && guard < 60) begin
      step(1'b1, 1'b0, 1'b0, "abort_run");
      guard++;
    end
    chk("abort_count4", {4'd0, bit_count}, 8'd4);
    step(1'b0, 1'b1, 1'b0, "abort_drop");
    chk("abort_busy", {7'd0, busy}, 8'd0);
    step(1'b0, 1'b0, 1'b0, "abort_idle");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "abort_restart");

    // Disable in the final strobe cycle of a byte.
    guard = 0;
    while (!(m_strobe() && (m_acc % BPB) == BPB - 1) && guard < 100) begin
      step(1'b1, 1'b0, 1'b0, "final_run");
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, "final_drop");
    chk("final_no_byte", {7'd0, byte_received}, 8'd0);
    step(1'b0, 1'b0, 1'b0, "final_idle");

    // Stuffed bit on the 3rd strobe.
    nstr  = 0;
    guard = 0;
    while (!byte_received && guard < 100) begin
      sk = m_strobe() && (nstr == 2);
      step(1'b1, 1'b0, sk, "stuff");
      if (shift_strobe) nstr++;
      guard++;
    end
    // Strobe seen in the byte cycle is the next byte's first, unless the phase lines up otherwise.
    if (byte_received && shift_strobe) nstr--;
    chk("stuff_strobes", 8'(nstr), STUFF ? 8'd9 : 8'd8);

    // Asynchronous reset mid-byte.
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0, "pre_arst");
    #2 n_rst = 1'b0;
    #1 model_reset();
    chk_all("arst_now");
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, "arst_hold");
    n_rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, "arst_release");

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 99) < 93);
      rs = ($urandom_range(0, 99) < 5);
      sk = ($urandom_range(0, 99) < 15);
      step(en, rs, sk, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
